pc_fetch_ctrl: RTL and testbench

Program-counter owner and fetch sequencer for the single-issue core; drives the 2-bit next-PC select and the resolved next PC that the PC-select multiplexer consumes. Holds the architectural PC, issues one instruction-memory fetch at a time with a req/ack handshake, and presents the fetched word to decode. On decode's consume it resolves the next PC from the branch/JAL/JALR indications. It encodes the choice using the mux's select convention:

- 00 = PC+4
- 01 = branch target
- 10 = JAL target
- 11 = JALR target with bit 0 cleared

---
 rtl/pc_fetch_ctrl.sv | 147 ++++++++++++++
 tb/tb_pc_fetch_ctrl.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/pc_fetch_ctrl.sv
// Program-counter owner and single-outstanding fetch sequencer with next-PC resolution.
// Optional misaligned-target trap enabled by defining PC_MISALIGN_TRAP_EN.
module pc_fetch_ctrl #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
`ifdef PC_MISALIGN_TRAP_EN
    ,
    parameter logic [31:0] TRAP_VEC = 32'h0000_0100
`endif
) (
    input  logic        clk_i,
    input  logic        rst_i,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_ack_i,
    input  logic [31:0] imem_rdata_i,
    output logic        instr_valid_o,
    output logic [31:0] instr_o,
    output logic [31:0] instr_pc_o,
    input  logic        dec_ready_i,
    input  logic        br_taken_i,
    input  logic        is_jal_i,
    input  logic        is_jalr_i,
    input  logic [31:0] br_target_i,
    input  logic [31:0] jal_target_i,
    input  logic [31:0] jalr_target_i,
    output logic [1:0]  pc_sel_o,
    output logic [31:0] next_pc_o,
    output logic        trap_o,
    output logic [31:0] trap_addr_o
);

    typedef enum logic [1:0] {StIdle, StFetch, StValid} state_e;

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] instr_pc_q, instr_pc_d;
    logic [1:0]  pc_sel_q, pc_sel_d;
    logic [31:0] next_pc_q, next_pc_d;
    logic [1:0]  sel;
    logic [31:0] target;

    // Resolution priority: JALR > JAL > branch > sequential.
    always_comb begin
        sel    = 2'b00;
        target = pc_q + 32'd4;
        if (is_jalr_i) begin
            sel    = 2'b11;
            target = {jalr_target_i[31:1], 1'b0};
        end else if (is_jal_i) begin
            sel    = 2'b10;
            target = jal_target_i;
        end else if (br_taken_i) begin
            sel    = 2'b01;
            target = br_target_i;
        end
    end

`ifdef PC_MISALIGN_TRAP_EN
    logic        trap_q, trap_d;
    logic [31:0] trap_addr_q, trap_addr_d;
`endif

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        instr_d    = instr_q;
        instr_pc_d = instr_pc_q;
        pc_sel_d   = pc_sel_q;
        next_pc_d  = next_pc_q;
`ifdef PC_MISALIGN_TRAP_EN
        trap_d      = 1'b0;
        trap_addr_d = trap_addr_q;
`endif
        case (state_q)
            StIdle: state_d = StFetch;
            StFetch: begin
                if (imem_ack_i) begin
                    instr_d    = imem_rdata_i;
                    instr_pc_d = pc_q;
                    state_d    = StValid;
                end
            end
            StValid: begin
                if (dec_ready_i) begin
                    pc_sel_d  = sel;
                    next_pc_d = target;
                    pc_d      = target;
                    state_d   = StFetch;
`ifdef PC_MISALIGN_TRAP_EN
                    if (target[1]) begin
                        next_pc_d   = TRAP_VEC;
                        pc_d        = TRAP_VEC;
                        trap_d      = 1'b1;
                        trap_addr_d = target;
                    end
`endif
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= StIdle;
            pc_q       <= RESET_PC;
            instr_q    <= 32'h0;
            instr_pc_q <= 32'h0;
            pc_sel_q   <= 2'b00;
            next_pc_q  <= RESET_PC;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            instr_q    <= instr_d;
            instr_pc_q <= instr_pc_d;
            pc_sel_q   <= pc_sel_d;
            next_pc_q  <= next_pc_d;
        end
    end

`ifdef PC_MISALIGN_TRAP_EN
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            trap_q      <= 1'b0;
            trap_addr_q <= 32'h0;
        end else begin
            trap_q      <= trap_d;
            trap_addr_q <= trap_addr_d;
        end
    end
    assign trap_o      = trap_q;
    assign trap_addr_o = trap_addr_q;
`else
    assign trap_o      = 1'b0;
    assign trap_addr_o = 32'h0;
`endif

    assign imem_req_o    = (state_q == StFetch);
    assign imem_addr_o   = pc_q;
    assign instr_valid_o = (state_q == StValid);
    assign instr_o       = instr_q;
    assign instr_pc_o    = instr_pc_q;
    assign pc_sel_o      = pc_sel_q;
    assign next_pc_o     = next_pc_q;

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Table-driven directed bench for pc_fetch_ctrl plus a hand-written reset-during-fetch sequence.
module tb_pc_fetch_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        instr_valid;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        dec_ready, br_taken, is_jal, is_jalr;
    logic [31:0] br_target, jal_target, jalr_target;
    logic [1:0]  pc_sel;
    logic [31:0] next_pc;
    logic        trap;
    logic [31:0] trap_addr;

    always #5 clk = ~clk;

    pc_fetch_ctrl dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .imem_req_o    (imem_req),
        .imem_addr_o   (imem_addr),
        .imem_ack_i    (imem_ack),
        .imem_rdata_i  (imem_rdata),
        .instr_valid_o (instr_valid),
        .instr_o       (instr),
        .instr_pc_o    (instr_pc),
        .dec_ready_i   (dec_ready),
        .br_taken_i    (br_taken),
        .is_jal_i      (is_jal),
        .is_jalr_i     (is_jalr),
        .br_target_i   (br_target),
        .jal_target_i  (jal_target),
        .jalr_target_i (jalr_target),
        .pc_sel_o      (pc_sel),
        .next_pc_o     (next_pc),
        .trap_o        (trap),
        .trap_addr_o   (trap_addr)
    );

`ifdef PC_MISALIGN_TRAP_EN
    localparam logic [31:0] MisPc   = 32'h0000_0100;
    localparam logic [31:0] SeqPc   = 32'h0000_0104;
    localparam logic        TrapExp = 1'b1;
    localparam logic [31:0] TaddExp = 32'h0000_0102;
`else
    localparam logic [31:0] MisPc   = 32'h0000_0102;
    localparam logic [31:0] SeqPc   = 32'h0000_0106;
    localparam logic        TrapExp = 1'b0;
    localparam logic [31:0] TaddExp = 32'h0000_0000;
`endif

    typedef struct {
        logic        ack;
        logic        dec;
        logic        br;
        logic        jal;
        logic        jalr;
        logic [31:0] bt;
        logic [31:0] jt;
        logic [31:0] jrt;
        logic        e_req;
        logic [31:0] e_addr;
        logic        e_valid;
        logic [31:0] e_instr;
        logic [31:0] e_ipc;
        logic [1:0]  e_sel;
        logic [31:0] e_npc;
        logic        e_trap;
        logic [31:0] e_taddr;
    } vec_t;

    localparam int NVec = 25;
    vec_t vecs[NVec];
    int   passed = 0;
    int   total  = 0;

    function automatic vec_t mk(input logic ack, dec, br, jal, jalr,
                                input logic [31:0] bt, jt, jrt,
                                input logic e_req, input logic [31:0] e_addr,
                                input logic e_valid, input logic [31:0] e_instr, e_ipc,
                                input logic [1:0] e_sel, input logic [31:0] e_npc,
                                input logic e_trap, input logic [31:0] e_taddr);
        vec_t v;
        v.ack = ack; v.dec = dec; v.br = br; v.jal = jal; v.jalr = jalr;
        v.bt = bt; v.jt = jt; v.jrt = jrt;
        v.e_req = e_req; v.e_addr = e_addr; v.e_valid = e_valid; v.e_instr = e_instr;
        v.e_ipc = e_ipc; v.e_sel = e_sel; v.e_npc = e_npc; v.e_trap = e_trap;
        v.e_taddr = e_taddr;
        return v;
    endfunction

    task automatic chk(input string name, input int idx, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp)
            $display("FAIL %s step %0d: got %h expected %h", name, idx, act, exp);
        else
            passed++;
    endtask

    task automatic chk_all(input int idx, input logic e_req, input logic [31:0] e_addr,
                           input logic e_valid, input logic [31:0] e_instr, e_ipc,
                           input logic [1:0] e_sel, input logic [31:0] e_npc,
                           input logic e_trap, input logic [31:0] e_taddr);
        chk("imem_req", idx, {31'h0, imem_req}, {31'h0, e_req});
        chk("imem_addr", idx, imem_addr, e_addr);
        chk("instr_valid", idx, {31'h0, instr_valid}, {31'h0, e_valid});
        chk("instr", idx, instr, e_instr);
        chk("instr_pc", idx, instr_pc, e_ipc);
        chk("pc_sel", idx, {30'h0, pc_sel}, {30'h0, e_sel});
        chk("next_pc", idx, next_pc, e_npc);
        chk("trap", idx, {31'h0, trap}, {31'h0, e_trap});
        chk("trap_addr", idx, trap_addr, e_taddr);
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    initial begin
        // ack dec br jal jalr  bt jt jrt | req addr valid instr ipc sel npc trap taddr
        vecs[0]  = mk(1, 1, 0, 0, 0, 0, 0, 0, 1, 32'h0, 0, 32'h0, 32'h0, 0, 32'h0, 0, 0);
        vecs[1]  = mk(1, 1, 0, 0, 0, 0, 0, 0, 0, 32'h0, 1, 32'hA02, 32'h0, 0, 32'h0, 0, 0);
        vecs[2]  = mk(0, 1, 0, 0, 0, 0, 0, 0, 1, 32'h4, 0, 32'hA02, 32'h0, 0, 32'h4, 0, 0);
        vecs[3]  = mk(1, 1, 0, 0, 0, 0, 0, 0, 0, 32'h4, 1, 32'hA04, 32'h4, 0, 32'h4, 0, 0);
        vecs[4]  = mk(0, 1, 0, 0, 0, 0, 0, 0, 1, 32'h8, 0, 32'hA04, 32'h4, 0, 32'h8, 0, 0);
        vecs[5]  = mk(1, 1, 0, 0, 0, 0, 0, 0, 0, 32'h8, 1, 32'hA06, 32'h8, 0, 32'h8, 0, 0);
        vecs[6]  = mk(0, 1, 0, 0, 1, 0, 0, 32'h1235,
                      1, 32'h1234, 0, 32'hA06, 32'h8, 3, 32'h1234, 0, 0);
        vecs[7]  = mk(1, 1, 0, 0, 0, 0, 0, 0,
                      0, 32'h1234, 1, 32'hA08, 32'h1234, 3, 32'h1234, 0, 0);
        vecs[8]  = mk(0, 1, 1, 1, 0, 32'h300, 32'h200, 0,
                      1, 32'h200, 0, 32'hA08, 32'h1234, 2, 32'h200, 0, 0);
        vecs[9]  = mk(1, 1, 0, 0, 0, 0, 0, 0,
                      0, 32'h200, 1, 32'hA0A, 32'h200, 2, 32'h200, 0, 0);
        vecs[10] = mk(0, 1, 1, 0, 0, 32'h300, 32'h200, 0,
                      1, 32'h300, 0, 32'hA0A, 32'h200, 1, 32'h300, 0, 0);
        vecs[11] = mk(1, 0, 0, 0, 0, 0, 0, 0,
                      0, 32'h300, 1, 32'hA0C, 32'h300, 1, 32'h300, 0, 0);
        // stalled decode; ack in VALID must not overwrite instr
        vecs[12] = mk(1, 0, 1, 1, 1, 32'h44, 32'h44, 32'h44,
                      0, 32'h300, 1, 32'hA0C, 32'h300, 1, 32'h300, 0, 0);
        vecs[13] = mk(0, 1, 0, 1, 0, 0, 32'hFFFF_FFFC, 0,
                      1, 32'hFFFF_FFFC, 0, 32'hA0C, 32'h300, 2, 32'hFFFF_FFFC, 0, 0);
        vecs[14] = mk(1, 1, 0, 0, 0, 0, 0, 0,
                      0, 32'hFFFF_FFFC, 1, 32'hA0F, 32'hFFFF_FFFC, 2, 32'hFFFF_FFFC, 0, 0);
        vecs[15] = mk(0, 1, 0, 0, 0, 0, 0, 0,
                      1, 32'h0, 0, 32'hA0F, 32'hFFFF_FFFC, 0, 32'h0, 0, 0);
        // three wait cycles; dec_ready/resolution in FETCH must be ignored
        vecs[16] = mk(0, 1, 0, 0, 1, 0, 0, 32'h800,
                      1, 32'h0, 0, 32'hA0F, 32'hFFFF_FFFC, 0, 32'h0, 0, 0);
        vecs[17] = mk(0, 1, 0, 1, 0, 0, 32'h800, 0,
                      1, 32'h0, 0, 32'hA0F, 32'hFFFF_FFFC, 0, 32'h0, 0, 0);
        vecs[18] = mk(0, 0, 0, 0, 0, 0, 0, 0,
                      1, 32'h0, 0, 32'hA0F, 32'hFFFF_FFFC, 0, 32'h0, 0, 0);
        vecs[19] = mk(1, 0, 0, 0, 0, 0, 0, 0,
                      0, 32'h0, 1, 32'hA14, 32'h0, 0, 32'h0, 0, 0);
        vecs[20] = mk(0, 1, 0, 0, 0, 0, 0, 0,
                      1, 32'h4, 0, 32'hA14, 32'h0, 0, 32'h4, 0, 0);
        vecs[21] = mk(1, 1, 0, 0, 0, 0, 0, 0,
                      0, 32'h4, 1, 32'hA16, 32'h4, 0, 32'h4, 0, 0);
        vecs[22] = mk(0, 1, 1, 0, 0, 32'h102, 0, 0,
                      1, MisPc, 0, 32'hA16, 32'h4, 1, MisPc, TrapExp, TaddExp);
        vecs[23] = mk(1, 1, 0, 0, 0, 0, 0, 0,
                      0, MisPc, 1, 32'hA18, MisPc, 1, MisPc, 0, TaddExp);
        vecs[24] = mk(0, 1, 0, 0, 0, 0, 0, 0,
                      1, SeqPc, 0, 32'hA18, MisPc, 0, SeqPc, 0, TaddExp);

        rst = 1'b1; imem_ack = 1'b0; imem_rdata = 32'h0; dec_ready = 1'b0;
        br_taken = 1'b0; is_jal = 1'b0; is_jalr = 1'b0;
        br_target = 32'h0; jal_target = 32'h0; jalr_target = 32'h0;
        repeat (2) step();
        chk_all(-1, 0, 32'h0, 0, 32'h0, 32'h0, 0, 32'h0, 0, 32'h0);

        rst = 1'b0;
        for (int i = 0; i < NVec; i++) begin
            imem_ack    = vecs[i].ack;
            imem_rdata  = 32'hA00 + 32'(i + 1);
            dec_ready   = vecs[i].dec;
            br_taken    = vecs[i].br;
            is_jal      = vecs[i].jal;
            is_jalr     = vecs[i].jalr;
            br_target   = vecs[i].bt;
            jal_target  = vecs[i].jt;
            jalr_target = vecs[i].jrt;
            step();
            chk_all(i + 1, vecs[i].e_req, vecs[i].e_addr, vecs[i].e_valid, vecs[i].e_instr,
                    vecs[i].e_ipc, vecs[i].e_sel, vecs[i].e_npc, vecs[i].e_trap,
                    vecs[i].e_taddr);
        end

        // Reset pulsed while FETCH is pending; the ack arriving next cycle is stale.
        dec_ready = 1'b0; br_taken = 1'b0; is_jal = 1'b0; is_jalr = 1'b0;
        rst = 1'b1; imem_ack = 1'b0;
        step();
        chk_all(100, 0, 32'h0, 0, 32'h0, 32'h0, 0, 32'h0, 0, 32'h0);
        rst = 1'b0; imem_ack = 1'b1; imem_rdata = 32'hDEAD_BEEF;
        step();
        chk_all(101, 1, 32'h0, 0, 32'h0, 32'h0, 0, 32'h0, 0, 32'h0);
        imem_ack = 1'b0;
        step();
        chk_all(102, 1, 32'h0, 0, 32'h0, 32'h0, 0, 32'h0, 0, 32'h0);
        imem_ack = 1'b1; imem_rdata = 32'h1111_2222;
        step();
        chk_all(103, 0, 32'h0, 1, 32'h1111_2222, 32'h0, 0, 32'h0, 0, 32'h0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
